cordic_job_dispatcher: RTL and testbench

//  Upstream sequencer for accelerator_top. Buffers float32 operands from the host/DMA side in an

---
 rtl/cordic_job_dispatcher.sv | 138 +++++++++++++
 tb/tb_cordic_job_dispatcher.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_dispatcher.sv
// rtl/cordic_job_dispatcher.sv - operand FIFO, single-job issue FSM with timeout, result FIFO
module cordic_job_dispatcher #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic                         acc_start,
  output logic [31:0]                  acc_x,
  input  logic                         acc_done,
  input  logic [31:0]                  acc_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic [$clog2(DEPTH+1)-1:0]   in_level,
  output logic                         busy,
  output logic                         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t        state, state_nx;
  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [PW-1:0] in_wr, in_rd, out_wr, out_rd;
  logic [CW-1:0] cnt;
  logic [31:0]   result;
  logic          in_empty, in_full, out_full;
  logic          push, pop, issue_go, store, expired;

  // Pointer-MSB decoding keeps full/empty correct across any number of wraps.
  assign in_empty  = (in_wr == in_rd);
  assign in_full   = (in_wr[AW] != in_rd[AW]) && (in_wr[AW-1:0] == in_rd[AW-1:0]);
  assign out_valid = (out_wr != out_rd);
  assign out_full  = (out_wr[AW] != out_rd[AW]) && (out_wr[AW-1:0] == out_rd[AW-1:0]);
  assign in_ready  = !in_full;
  assign in_level  = LW'(in_wr - in_rd);
  assign out_data  = out_mem[out_rd[AW-1:0]];
  assign busy      = (state != S_IDLE);

  assign push     = in_valid && !in_full;
  assign pop      = out_valid && out_ready;
  // Out-FIFO space is reserved here, so a stalled consumer can never cost a result.
  assign issue_go = (state == S_IDLE) && !in_empty && !out_full;
  assign store    = (state == S_STORE);
  assign expired  = (cnt == CW'(TIMEOUT - 1));

  // State register, frozen while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state <= S_IDLE;
    else if (clk_en) state <= state_nx;
  end

  // Next-state decode and the single-cycle start pulse.
  always_comb begin
    state_nx  = state;
    acc_start = 1'b0;
    case (state)
      S_IDLE:  if (issue_go) state_nx = S_ISSUE;
      S_ISSUE: begin
        acc_start = clk_en;
        state_nx  = S_WAIT;
      end
      S_WAIT:  if (acc_done || expired) state_nx = S_STORE;
      S_STORE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Input FIFO pointers: host push and FSM pop may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wr <= '0;
      in_rd <= '0;
    end else if (clk_en) begin
      if (push)     in_wr <= in_wr + 1'b1;
      if (issue_go) in_rd <= in_rd + 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (push)  in_mem[in_wr[AW-1:0]]   <= in_data;
      if (store) out_mem[out_wr[AW-1:0]] <= result;
    end
  end

  // Operand register: loaded from the FIFO head when a job leaves IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    acc_x <= '0;
    else if (clk_en && issue_go)  acc_x <= in_mem[in_rd[AW-1:0]];
  end

  // Timeout counter, result capture and sticky error; done wins over timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (clk_en) begin
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        if (acc_done) begin
          result <= acc_y;
        end else if (expired) begin
          result <= QNAN;
          err    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Output FIFO pointers: STORE writes, consumer pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr <= '0;
      out_rd <= '0;
    end else if (clk_en) begin
      if (store) out_wr <= out_wr + 1'b1;
      if (pop)   out_rd <= out_rd + 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_job_dispatcher.sv
// tb/tb_cordic_job_dispatcher.sv - directed bench for cordic_job_dispatcher with accelerator stub
module tb_cordic_job_dispatcher;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        acc_start;
  logic [31:0] acc_x;
  wire         acc_done;
  logic [31:0] acc_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  in_level;
  logic        busy;
  logic        err;

  logic        stub_done;
  logic        force_done;
  logic [31:0] stub_resp;
  logic [31:0] fixed_val;
  int          stub_cnt;
  int          stub_delay;
  bit          stub_hang;
  bit          stub_fixed;
  int          start_cnt;

  int          n_vec;
  int          n_bad;
  logic [31:0] exp_q[$];

  assign acc_done = stub_done | force_done;

  cordic_job_dispatcher dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .acc_start (acc_start),
    .acc_x     (acc_x),
    .acc_done  (acc_done),
    .acc_y     (acc_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .in_level  (in_level),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accelerator stub: answers acc_x+1 (or a fixed value) a set number of cycles after start.
  initial begin
    stub_done = 1'b0;
    acc_y     = '0;
    stub_resp = '0;
    stub_cnt  = 0;
    start_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      stub_done = 1'b0;
      if (reset) begin
        stub_cnt = 0;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_done = 1'b1;
          acc_y     = stub_resp;
        end
      end
      if (acc_start) begin
        start_cnt++;
        if (!stub_hang) begin
          stub_cnt  = stub_delay;
          stub_resp = stub_fixed ? fixed_val : acc_x + 32'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit track);
    int n = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 300) begin
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, ok}, 32'd1);
    if (track) exp_q.push_back(d + 32'd1);
  endtask

  task automatic wait_out(input string tag, input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    wait_out({tag, "_valid"}, 300);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int got;
    int cyc;
    bit r;
    logic [31:0] e;
    n_vec = 0; n_bad = 0;
    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; force_done = 1'b0;
    stub_delay = 3; stub_hang = 1'b0; stub_fixed = 1'b0; fixed_val = '0;

    repeat (2) tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc_start", {31'd0, acc_start}, 32'd0);
    chk("rst_acc_x",     acc_x,              32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_in_level",  {28'd0, in_level},  32'd0);
    reset = 1'b0;
    tick();

    // Single job with a 20-cycle accelerator.
    stub_fixed = 1'b1; fixed_val = 32'h3F80_0000; stub_delay = 20;
    s0 = start_cnt;
    push(32'h4360_0000, 1'b0);
    wait_out("t1_valid", 100);
    chk("t1_starts", start_cnt - s0, 32'd1);
    chk("t1_acc_x",  acc_x, 32'h4360_0000);
    chk("t1_busy",   {31'd0, busy}, 32'd0);
    pop_chk("t1_data", 32'h3F80_0000);
    chk("t1_empty",  {31'd0, out_valid}, 32'd0);
    stub_fixed = 1'b0; stub_delay = 3;

    // clk_en low while in ISSUE suppresses the start pulse.
    s0 = start_cnt;
    in_valid = 1'b1; in_data = 32'h4049_0FDB;
    tick();
    in_valid = 1'b0;
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1;
      chk("t5_start_gated", {31'd0, acc_start}, 32'd0);
    end
    tick();
    clk_en = 1'b1;
    pop_chk("t5_data", 32'h4049_0FDC);
    chk("t5_starts", start_cnt - s0, 32'd1);

    // Out FIFO fills with consumer stalled, then the input FIFO fills behind it.
    stub_delay = 2;
    for (int i = 0; i < 8; i++) push(32'h3F80_0000 + 32'(i) * 32'h0010_0000, 1'b1);
    repeat (100) tick();
    chk("t2_busy_full",   {31'd0, busy},      32'd0);
    chk("t2_in_level0",   {28'd0, in_level},  32'd0);
    for (int i = 0; i < 8; i++) push(32'h4100_0000 + 32'(i), 1'b1);
    repeat (3) tick();
    chk("t2_in_level8",   {28'd0, in_level},  32'd8);
    chk("t2_in_ready",    {31'd0, in_ready},  32'd0);
    chk("t2_busy_idle",   {31'd0, busy},      32'd0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      pop_chk("t2_order", e);
    end

    // Stream 20 jobs against a randomly stalling consumer.
    stub_delay = 4;
    got = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) push(32'hC000_0000 + 32'(i) * 32'h0000_0101, 1'b1);
      end
      begin
        cyc = 0;
        while (got < 20 && cyc < 3000) begin
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (out_valid && r) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 32'hFFFF_FFFF;
            chk("t6_order", out_data, e);
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("t6_count", got, 32'd20);

    // Hung accelerator times out; the following job is unaffected.
    stub_hang = 1'b1;
    push(32'h1111_1111, 1'b0);
    pop_chk("t3_qnan", 32'h7FC0_0000);
    chk("t3_err", {31'd0, err}, 32'd1);
    stub_hang = 1'b0;
    push(32'h2222_2222, 1'b0);
    pop_chk("t3_next", 32'h2222_2223);
    chk("t3_err_sticky", {31'd0, err}, 32'd1);

    // Reset during WAIT; a late done must not create a result.
    stub_delay = 30;
    push(32'h3333_3333, 1'b0);
    repeat (6) tick();
    chk("t4_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (5) tick();
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_in_level",  {28'd0, in_level},  32'd0);
    chk("t4_err",       {31'd0, err},       32'd0);
    chk("t4_busy",      {31'd0, busy},      32'd0);
    chk("t4_acc_x",     acc_x,              32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
